alu_mdu: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle RV32I integer ALU. It keeps the base RV I-type/R-type arithmetic, logic, shift and compare operations and adds the M-extension operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) through an iterative shift-add multiplier and a restoring divider. The block sits in the execute stage, between operand-read and writeback. It uses a valid/ready handshake on both sides so the pipeline can stall while a multiply or divide is iterating.

---
 rtl/alu_mdu.sv | 218 +++++++++++++++++++++
 tb/tb_alu_mdu.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// Execute-stage integer ALU with iterative M-extension multiply/divide.
// Valid/ready on both sides; base ops and divide special cases finish in one cycle.
module alu_mdu #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN + 1);
    localparam int unsigned RW = XLEN + 1;
    localparam int unsigned PW = 2 * XLEN;
    localparam logic [6:0]      F7_ALT  = 7'h20;
    localparam logic [6:0]      F7_M    = 7'h01;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_IT,
        S_DIV_IT,
        S_FIX,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]   opd_q, opd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    // Single-cycle base operations
    logic            alt;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res;

    always_comb begin
        alt      = (funct7 == F7_ALT);
        shamt    = B[SHW-1:0];
        base_res = '0;
        unique case (funct3)
            3'd0: base_res = alt ? A - B : A + B;
            3'd1: base_res = A << shamt;
            3'd2: base_res = XLEN'($signed(A) < $signed(B));
            3'd3: base_res = XLEN'(A < B);
            3'd4: base_res = A ^ B;
            3'd5: base_res = alt ? $unsigned($signed(A) >>> shamt) : A >> shamt;
            3'd6: base_res = A | B;
            3'd7: base_res = A & B;
            default: base_res = '0;
        endcase
    end

    // Operand magnitudes, result sign and divide special cases at accept
    logic            is_m, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    always_comb begin
        is_m = (funct7 == F7_M);
        if (funct3[2]) begin
            a_sgn = ~funct3[0];
            b_sgn = ~funct3[0];
        end else begin
            a_sgn = (funct3 == 3'd1) || (funct3 == 3'd2);
            b_sgn = (funct3 == 3'd1);
        end
        a_neg    = a_sgn & A[XLEN-1];
        b_neg    = b_sgn & B[XLEN-1];
        a_mag    = a_neg ? ~A + XLEN'(1) : A;
        b_mag    = b_neg ? ~B + XLEN'(1) : B;
        div_zero = (B == '0);
        div_ovf  = a_sgn && (A == MIN_NEG) && (B == '1);
        if (div_zero) begin
            special_res = funct3[1] ? A : '1;
        end else begin
            special_res = funct3[1] ? '0 : A;
        end
    end

    // One shift-add / restoring-subtract step, plus the final sign fix-up
    logic [XLEN:0]   mul_sum;
    logic [PW-1:0]   mul_acc, div_acc, prod_fix;
    logic [RW-1:0]   rem_sh, div_rem;
    logic            div_ge;
    logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        mul_acc  = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = (rem_q << 1) | RW'(acc_q[XLEN-1]);
        div_ge   = (rem_sh >= {1'b0, opd_q});
        div_rem  = div_ge ? rem_sh - {1'b0, opd_q} : rem_sh;
        div_acc  = {acc_q[PW-1:XLEN], acc_q[XLEN-2:0], div_ge};
        prod_fix = neg_q ? ~acc_q + PW'(1) : acc_q;
        quo_fix  = neg_q ? ~acc_q[XLEN-1:0] + XLEN'(1) : acc_q[XLEN-1:0];
        rem_fix  = neg_q ? ~rem_q[XLEN-1:0] + XLEN'(1) : rem_q[XLEN-1:0];
        if (op_q[2]) begin
            fix_res = op_q[1] ? rem_fix : quo_fix;
        end else if (op_q == 3'd0) begin
            fix_res = prod_fix[XLEN-1:0];
        end else begin
            fix_res = prod_fix[PW-1:XLEN];
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        opd_d       = opd_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        neg_d       = neg_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!is_m) begin
                        result_d    = base_res;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (funct3[2] && (div_zero || div_ovf)) begin
                        result_d    = special_res;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        op_d    = funct3;
                        neg_d   = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
                        opd_d   = b_mag;
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        rem_d   = '0;
                        cnt_d   = CW'(XLEN);
                        busy_d  = 1'b1;
                        state_d = funct3[2] ? S_DIV_IT : S_MUL_IT;
                    end
                end
            end
            S_MUL_IT: begin
                acc_d = mul_acc;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_DIV_IT: begin
                acc_d = div_acc;
                rem_d = div_rem;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d    = fix_res;
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            rem_q       <= '0;
            opd_q       <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            opd_q       <= opd_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !reset;
    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Randomised and directed bench for alu_mdu at XLEN=32 and XLEN=64,
// checked against a wide-arithmetic reference model.
module tb_alu_mdu;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic        sel64;
    logic [63:0] a_in, b_in;
    logic [2:0]  f3_in;
    logic [6:0]  f7_in;

    logic        ir32, ov32, bz32, ir64, ov64, bz64;
    logic [31:0] r32;
    logic [63:0] r64;
    logic        ir, ov, bz;
    logic [63:0] res;

    int n_checks = 0;
    int n_errors = 0;

    alu_mdu #(.XLEN(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid & ~sel64), .in_ready(ir32),
        .A(a_in[31:0]), .B(b_in[31:0]), .funct3(f3_in), .funct7(f7_in),
        .out_valid(ov32), .out_ready(out_ready), .Result(r32), .busy(bz32)
    );

    alu_mdu #(.XLEN(64)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid & sel64), .in_ready(ir64),
        .A(a_in), .B(b_in), .funct3(f3_in), .funct7(f7_in),
        .out_valid(ov64), .out_ready(out_ready), .Result(r64), .busy(bz64)
    );

    assign ir  = sel64 ? ir64 : ir32;
    assign ov  = sel64 ? ov64 : ov32;
    assign bz  = sel64 ? bz64 : bz32;
    assign res = sel64 ? r64 : {32'h0, r32};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mask_of(input bit w64);
        return w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Reference: RV semantics evaluated on 128-bit signed/unsigned integers
    function automatic logic [63:0] ref_model(input bit w64, input logic [63:0] a, input logic [63:0] b,
                                              input logic [2:0] f3, input logic [6:0] f7);
        logic [63:0]         mask, am, bm, r;
        logic signed [127:0] sa, sb, ua, ub, p;
        int unsigned         xl, sh;
        bit                  alt;
        mask = mask_of(w64);
        xl   = w64 ? 64 : 32;
        am   = a & mask;
        bm   = b & mask;
        sa   = w64 ? {{64{a[63]}}, a} : {{96{a[31]}}, a[31:0]};
        sb   = w64 ? {{64{b[63]}}, b} : {{96{b[31]}}, b[31:0]};
        ua   = {64'h0, am};
        ub   = {64'h0, bm};
        sh   = w64 ? int'(b[5:0]) : int'(b[4:0]);
        alt  = (f7 == 7'h20);
        r    = '0;
        if (f7 != 7'h01) begin
            case (f3)
                3'd0: r = alt ? am - bm : am + bm;
                3'd1: r = am << sh;
                3'd2: r = (sa < sb) ? 64'd1 : 64'd0;
                3'd3: r = (ua < ub) ? 64'd1 : 64'd0;
                3'd4: r = am ^ bm;
                3'd5: r = alt ? 64'(sa >>> sh) : am >> sh;
                3'd6: r = am | bm;
                default: r = am & bm;
            endcase
        end else begin
            case (f3)
                3'd0: begin p = ua * ub; r = p[63:0]; end
                3'd1: begin p = sa * sb; r = 64'(p >> xl); end
                3'd2: begin p = sa * ub; r = 64'(p >> xl); end
                3'd3: begin p = ua * ub; r = 64'(p >> xl); end
                3'd4: r = (bm == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(sa / sb);
                3'd5: r = (bm == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(ua / ub);
                3'd6: r = (bm == 0) ? am : 64'(sa % sb);
                default: r = (bm == 0) ? am : 64'(ua % ub);
            endcase
        end
        return r & mask;
    endfunction

    function automatic logic [63:0] pick(input bit w64);
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0: v = 64'h0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = w64 ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
            3: v = 64'($urandom_range(0, 9));
            default: v = {$urandom, $urandom};
        endcase
        return v & mask_of(w64);
    endfunction

    // Issue one op, check latency, busy span, result, hold stability and hand-off
    task automatic run_op(input bit w64, input logic [63:0] a, input logic [63:0] b,
                          input logic [2:0] f3, input logic [6:0] f7, input int hold,
                          input logic [63:0] exp);
        logic [63:0] mask, amin;
        bit          special;
        int          exp_lat, lat, busy_n, n;
        string       id;
        mask    = mask_of(w64);
        amin    = w64 ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
        special = f3[2] && (((b & mask) == 0) ||
                            (!f3[0] && (a & mask) == amin && (b & mask) == mask));
        exp_lat = (f7 == 7'h01 && !special) ? (w64 ? 65 : 33) : 1;
        id      = $sformatf("x%0d f7=%h f3=%0d a=%h b=%h", w64 ? 64 : 32, f7, f3, a, b);
        sel64   = w64;
        #1;
        n = 0;
        while (!ir && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 200) check({"ready_timeout ", id}, 64'(ir), 64'd1);
        a_in     = a;
        b_in     = b;
        f3_in    = f3;
        f7_in    = f7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in     = {$urandom, $urandom};
        b_in     = {$urandom, $urandom};
        f3_in    = 3'($urandom);
        f7_in    = 7'($urandom);
        lat      = 0;
        busy_n   = 0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (ov) break;
            if (bz) busy_n++;
        end
        check({"latency ", id}, 64'(lat), 64'(exp_lat));
        check({"busy_cycles ", id}, 64'(busy_n), 64'(exp_lat - 1));
        check({"result ", id}, res, exp);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        if (hold > 0) begin
            check({"hold_result ", id}, res, exp);
            check({"hold_ready ", id}, 64'(ir), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({"drained ", id}, {62'h0, ov, ir}, 64'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel64     = 1'b0;
        a_in      = '0;
        b_in      = '0;
        f3_in     = '0;
        f7_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state32", {ir32, ov32, bz32, 32'h0, r32}, 64'h0);
        check("reset_state64", {61'h0, ir64, ov64, bz64}, 64'h0);
        check("reset_result64", r64, 64'h0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", {62'h0, ir32, ir64}, 64'd3);

        run_op(0, 64'h8000_0000, 64'd4, 3'd5, 7'h20, 0, 64'hF800_0000);
        run_op(0, 64'h8000_0000, 64'd4, 3'd5, 7'h00, 0, 64'h0800_0000);
        run_op(0, 64'hFFFF_FFFF, 64'd2, 3'd0, 7'h01, 0, 64'hFFFF_FFFE);
        run_op(0, 64'hFFFF_FFFF, 64'd2, 3'd1, 7'h01, 0, 64'hFFFF_FFFF);
        run_op(0, 64'hFFFF_FFFF, 64'd2, 3'd3, 7'h01, 0, 64'h0000_0001);
        run_op(0, 64'hFFFF_FFFF, 64'd2, 3'd2, 7'h01, 0, 64'hFFFF_FFFF);
        run_op(0, 64'd7, 64'd0, 3'd5, 7'h01, 0, 64'hFFFF_FFFF);
        run_op(0, 64'd7, 64'd0, 3'd7, 7'h01, 0, 64'd7);
        run_op(0, 64'h8000_0000, 64'hFFFF_FFFF, 3'd4, 7'h01, 0, 64'h8000_0000);
        run_op(0, 64'h8000_0000, 64'hFFFF_FFFF, 3'd6, 7'h01, 0, 64'h0);
        run_op(0, 64'hFFFF_FFF9, 64'd2, 3'd4, 7'h01, 0, 64'hFFFF_FFFD);
        run_op(0, 64'hFFFF_FFF9, 64'd2, 3'd6, 7'h01, 0, 64'hFFFF_FFFF);
        run_op(1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'd4, 7'h01, 0, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'd6, 7'h01, 0, 64'hFFFF_FFFF_FFFF_FFFF);

        // Backpressure: result holds, in_valid ignored until the hand-off
        sel64 = 1'b0;
        a_in = 64'd10; b_in = 64'd20; f3_in = 3'd0; f7_in = 7'h00;
        in_valid = 1'b1;
        @(posedge clk); #1;
        a_in = 64'd3; b_in = 64'd4;
        check("bp_first", {ov32, 31'h0, r32}, {1'b1, 31'h0, 32'd30});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d", i), {ov32, ir32, 30'h0, r32}, {2'b10, 30'h0, 32'd30});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release", {62'h0, ov32, ir32}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_accept", {ov32, ir32, 30'h0, r32}, {2'b10, 30'h0, 32'd7});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of a divide abandons it
        a_in = 64'd1000; b_in = 64'd3; f3_in = 3'd5; f7_in = 7'h01;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_div_busy", 64'(bz32), 64'd1);
        reset = 1'b1;
        in_valid = 1'b1;
        a_in = 64'd1; b_in = 64'd1; f3_in = 3'd0; f7_in = 7'h00;
        @(posedge clk); #1;
        check("reset_abandon", {ov32, bz32, ir32, 29'h0, r32}, 64'h0);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check("reset_idle_ready", 64'(ir32), 64'd1);
        @(posedge clk); #1;
        check("reset_no_accept", 64'(ov32), 64'd0);
        run_op(0, 64'd100, 64'd7, 3'd5, 7'h01, 0, 64'd14);
        run_op(0, 64'd100, 64'd7, 3'd7, 7'h01, 0, 64'd2);

        for (int i = 0; i < 160; i++) begin
            bit          w;
            logic [6:0]  f7;
            logic [2:0]  f3;
            logic [63:0] a, b;
            w = (i % 4 == 3);
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            f3 = 3'($urandom);
            a  = pick(w);
            b  = pick(w);
            run_op(w, a, b, f3, f7, $urandom_range(0, 2), ref_model(w, a, b, f3, f7));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
